mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and memory stages onto one SRAM-like bus, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build gives data priority.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q;
  logic        owner_q;   // 0 = inst, 1 = data
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        pick_data;
  logic        wr_d;
  logic [1:0]  size_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        idle;
  logic        grant;
  logic        done;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q;  // 1 = data was granted last
  assign pick_data = data_req & (~inst_req | ~rr_last_q);
`else
  assign pick_data = data_req;
`endif

  assign wr_d    = pick_data ? data_wr    : inst_wr;
  assign size_d  = pick_data ? data_size  : inst_size;
  assign addr_d  = pick_data ? data_addr  : inst_addr;
  assign wdata_d = pick_data ? data_wdata : inst_wdata;

  assign idle  = (state_q == S_IDLE);
  assign grant = idle & (inst_req | data_req) & ~reset;
  // Handshakes are masked during reset so an abandoned transaction never completes.
  assign done  = ~reset & bus_data_ok &
                 (((state_q == S_REQ) & bus_addr_ok) | (state_q == S_WAIT));

  assign inst_addr_ok = grant & ~pick_data;
  assign data_addr_ok = grant &  pick_data;
  assign inst_data_ok = done  & ~owner_q;
  assign data_data_ok = done  &  owner_q;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req   = (state_q == S_REQ);
  assign bus_wr    = idle ? 1'b0  : wr_q;
  assign bus_size  = idle ? 2'd0  : size_q;
  assign bus_addr  = idle ? 32'd0 : addr_q;
  assign bus_wdata = idle ? 32'd0 : wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (inst_req | data_req) begin
            state_q <= S_REQ;
            owner_q <= pick_data;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q <= pick_data;
`endif
          end
        end
        S_REQ: begin
          if (bus_addr_ok) state_q <= bus_data_ok ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (bus_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int checks = 0;
  int failures = 0;

  // Model: an outstanding transaction, whether the slave has taken its address, and its fields.
  bit          m_busy = 1'b0;
  bit          m_acc = 1'b0;
  bit          m_own_data = 1'b0;
  bit          m_last_data = 1'b0;
  bit          m_wr = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    bit data_wins, grant, fin;
`ifdef ARB_ROUND_ROBIN_EN
    data_wins = data_req && !(inst_req && m_last_data);
`else
    data_wins = data_req;
`endif
    grant = !reset && !m_busy && (inst_req || data_req);
    fin   = !reset && m_busy && bus_data_ok && (m_acc || bus_addr_ok);
    chk("m_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, grant && !data_wins});
    chk("m_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, grant && data_wins});
    chk("m_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, fin && !m_own_data});
    chk("m_data_data_ok", {31'd0, data_data_ok}, {31'd0, fin && m_own_data});
    chk("m_bus_req", {31'd0, bus_req}, {31'd0, m_busy && !m_acc});
    chk("m_bus_wr", {31'd0, bus_wr}, {31'd0, m_busy && m_wr});
    chk("m_bus_size", {30'd0, bus_size}, m_busy ? {30'd0, m_size} : 32'd0);
    chk("m_bus_addr", bus_addr, m_busy ? m_addr : 32'd0);
    chk("m_bus_wdata", bus_wdata, m_busy ? m_wdata : 32'd0);
    chk("m_inst_rdata", inst_rdata, bus_rdata);
    chk("m_data_rdata", data_rdata, bus_rdata);
    // Advance to the state that holds after the coming rising edge.
    if (reset) begin
      m_busy = 1'b0; m_acc = 1'b0; m_own_data = 1'b0; m_last_data = 1'b0;
      m_wr = 1'b0; m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0;
    end else if (grant) begin
      m_busy = 1'b1; m_acc = 1'b0; m_own_data = data_wins; m_last_data = data_wins;
      m_wr    = data_wins ? data_wr    : inst_wr;
      m_size  = data_wins ? data_size  : inst_size;
      m_addr  = data_wins ? data_addr  : inst_addr;
      m_wdata = data_wins ? data_wdata : inst_wdata;
    end else if (fin) begin
      m_busy = 1'b0; m_acc = 1'b0;
    end else if (m_busy && !m_acc && bus_addr_ok) begin
      m_acc = 1'b1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'h0;
    step(); step();
    reset = 1'b0;

    // Reset state
    sample();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    adv();

    // Single read from fetch stage
    inst_req = 1; inst_addr = 32'hBFC00000; inst_wr = 0;
    sample();
    chk("rd_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("rd_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    adv();
    inst_req = 0; inst_addr = 32'h12345678; bus_addr_ok = 1;
    sample();
    chk("rd_bus_req", {31'd0, bus_req}, 32'd1);
    chk("rd_bus_addr", bus_addr, 32'hBFC00000);
    chk("rd_bus_wr", {31'd0, bus_wr}, 32'd0);
    adv();
    bus_addr_ok = 0;
    step();
    bus_data_ok = 1; bus_rdata = 32'h3C1D0000;
    sample();
    chk("rd_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("rd_inst_rdata", inst_rdata, 32'h3C1D0000);
    chk("rd_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    adv();
    bus_data_ok = 0;
    sample();
    chk("rd_inst_data_ok_end", {31'd0, inst_data_ok}, 32'd0);
    adv();

    // Collision: data wins, inst waits for data_data_ok
    inst_req = 1; inst_addr = 32'h00000040; data_req = 1; data_addr = 32'h00000080;
    sample();
    chk("col_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("col_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    adv();
    data_req = 0; bus_addr_ok = 1;
    sample();
    chk("col_bus_addr", bus_addr, 32'h00000080);
    chk("col_inst_hold", {31'd0, inst_addr_ok}, 32'd0);
    adv();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hA5A5A5A5;
    sample();
    chk("col_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("col_inst_wait", {31'd0, inst_addr_ok}, 32'd0);
    adv();
    bus_data_ok = 0;
    sample();
    chk("col_inst_addr_ok2", {31'd0, inst_addr_ok}, 32'd1);
    adv();

    // Zero-latency slave, followed by a write grant on the very next cycle
    inst_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0BADF00D;
    data_req = 1; data_wr = 1; data_size = 2'd2;
    data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    sample();
    chk("zl_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("zl_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    adv();
    bus_addr_ok = 0; bus_data_ok = 0;
    sample();
    chk("zl_next_grant", {31'd0, data_addr_ok}, 32'd1);
    adv();

    // Write held steady through three stalled cycles while inputs change
    data_req = 0;
    for (int i = 0; i < 3; i++) begin
      data_addr = 32'h11110000 + i; data_wdata = 32'h0; data_wr = 0; inst_req = 1;
      sample();
      chk("wr_bus_addr", bus_addr, 32'h80001000);
      chk("wr_bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("wr_bus_wr", {31'd0, bus_wr}, 32'd1);
      chk("wr_bus_size", {30'd0, bus_size}, 32'd2);
      adv();
    end
    inst_req = 0; bus_addr_ok = 1;
    sample();
    chk("wr_bus_req", {31'd0, bus_req}, 32'd1);
    adv();
    bus_addr_ok = 0; bus_data_ok = 1;
    sample();
    chk("wr_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    adv();
    bus_data_ok = 0;

    // Reset while in WAIT, then a late bus_data_ok
    inst_req = 1; inst_addr = 32'h00002000;
    step();
    inst_req = 0; bus_addr_ok = 1;
    step();
    bus_addr_ok = 0;
    step();
    reset = 1;
    step();
    reset = 0; bus_data_ok = 1;
    sample();
    chk("rst_late_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_late_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("rst_late_bus_req", {31'd0, bus_req}, 32'd0);
    adv();

    // Stray bus_data_ok in IDLE with no requests
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stray_hs", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
      adv();
    end
    bus_data_ok = 0;
    // Idle after the stray pulses must still grant normally
    data_req = 1; data_addr = 32'h00003000; data_wr = 0;
    sample();
    chk("stray_then_grant", {31'd0, data_addr_ok}, 32'd1);
    adv();
    data_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
